// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order-retire reorder buffer with CDB capture and mispredict flush
//
// Ports:
//   clk, rst, rdy           clock, async active-high reset, global enable (low freezes state)
//   issue_*                 in-order allocation from the decoder; issue_tag is the tail entry
//   rob_full                registered count has reached ROB_SIZE
//   cdb_*                   result broadcast; completes a busy entry
//   query{1,2}_*            operand lookup for reservation stations, with same-cycle CDB bypass
//   commit_*                registered one-cycle retirement pulses and their payload
//   flush, flush_pc         registered mispredict pulse and redirect PC
module reorder_buffer #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic                 issue_valid,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_taken,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] issue_tag,

    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_taken,
    input  logic [31:0]          cdb_target,

    input  logic [ROB_WIDTH-1:0] query1_tag,
    input  logic [ROB_WIDTH-1:0] query2_tag,
    output logic                 query1_ready,
    output logic                 query2_ready,
    output logic [31:0]          query1_val,
    output logic [31:0]          query2_val,

    output logic                 commit_rf_en,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic                 commit_store_en,
    output logic                 flush,
    output logic [31:0]          flush_pc
);

    localparam logic [1:0]         T_REG    = 2'd0;
    localparam logic [1:0]         T_STORE  = 2'd1;
    localparam logic [1:0]         T_BRANCH = 2'd2;
    localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);
    localparam logic [ROB_WIDTH-1:0] PTR_ONE  = ROB_WIDTH'(1);

    // Control state (async reset)
    logic [ROB_SIZE-1:0]  busy_q, busy_d;
    logic [ROB_SIZE-1:0]  ready_q, ready_d;
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Entry payload; only meaningful while busy, so it carries no reset
    logic [1:0]  type_q   [ROB_SIZE];
    logic [4:0]  rd_q     [ROB_SIZE];
    logic [31:0] val_q    [ROB_SIZE];
    logic [31:0] pc_q     [ROB_SIZE];
    logic        pred_q   [ROB_SIZE];
    logic        taken_q  [ROB_SIZE];
    logic [31:0] target_q [ROB_SIZE];

    // Registered retirement outputs
    logic                 commit_rf_en_q, commit_rf_en_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic                 commit_store_en_q, commit_store_en_d;
    logic                 flush_q, flush_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic       issue_fire, cdb_fire, commit_fire, mispredict;
    logic [1:0] issue_type_n;
    logic [1:0] head_type;

    assign rob_full  = (count_q == CNT_FULL);
    assign issue_tag = tail_q;

    // Reserved type 3 behaves as a plain register write
    assign issue_type_n = (issue_type == 2'd3) ? T_REG : issue_type;

    // The cycle after a flush drops issue and CDB traffic belonging to the squashed path
    assign issue_fire  = issue_valid && !rob_full && rdy && !flush_q;
    assign cdb_fire    = cdb_valid && rdy && !flush_q && busy_q[cdb_tag];
    // Uses registered ready, so a CDB result retires no earlier than the next cycle
    assign commit_fire = rdy && busy_q[head_q] && ready_q[head_q];
    assign head_type   = type_q[head_q];
    assign mispredict  = commit_fire && (head_type == T_BRANCH)
                         && (taken_q[head_q] != pred_q[head_q]);

    // Operand lookup with bypass from the broadcast in flight this cycle
    always_comb begin
        query1_ready = 1'b0;
        query1_val   = 32'd0;
        if (busy_q[query1_tag]) begin
            if (cdb_valid && (cdb_tag == query1_tag)) begin
                query1_ready = 1'b1;
                query1_val   = cdb_val;
            end else if (ready_q[query1_tag]) begin
                query1_ready = 1'b1;
                query1_val   = val_q[query1_tag];
            end
        end
    end

    always_comb begin
        query2_ready = 1'b0;
        query2_val   = 32'd0;
        if (busy_q[query2_tag]) begin
            if (cdb_valid && (cdb_tag == query2_tag)) begin
                query2_ready = 1'b1;
                query2_val   = cdb_val;
            end else if (ready_q[query2_tag]) begin
                query2_ready = 1'b1;
                query2_val   = val_q[query2_tag];
            end
        end
    end

    // Pointer, occupancy and status-bit next state
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (cdb_fire) begin
            ready_d[cdb_tag] = 1'b1;
        end
        if (commit_fire) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (issue_fire) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + PTR_ONE;
        end
        case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A mispredict squashes everything, including any same-edge issue
        if (mispredict) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Retirement outputs; pulses fall to zero whenever nothing commits (incl. rdy low)
    always_comb begin
        commit_rf_en_d    = commit_fire && (head_type == T_REG) && (rd_q[head_q] != 5'd0);
        commit_store_en_d = commit_fire && (head_type == T_STORE);
        flush_d           = mispredict;
        commit_rd_d       = commit_rd_q;
        commit_val_d      = commit_val_q;
        commit_tag_d      = commit_tag_q;
        flush_pc_d        = flush_pc_q;

        if (commit_fire) begin
            commit_tag_d = head_q;
            if (head_type == T_REG) begin
                commit_rd_d  = rd_q[head_q];
                commit_val_d = val_q[head_q];
            end
        end
        if (mispredict) begin
            flush_pc_d = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q            <= '0;
            ready_q           <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_rf_en_q    <= 1'b0;
            commit_rd_q       <= 5'd0;
            commit_val_q      <= 32'd0;
            commit_tag_q      <= '0;
            commit_store_en_q <= 1'b0;
            flush_q           <= 1'b0;
            flush_pc_q        <= 32'd0;
        end else begin
            busy_q            <= busy_d;
            ready_q           <= ready_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_rf_en_q    <= commit_rf_en_d;
            commit_rd_q       <= commit_rd_d;
            commit_val_q      <= commit_val_d;
            commit_tag_q      <= commit_tag_d;
            commit_store_en_q <= commit_store_en_d;
            flush_q           <= flush_d;
            flush_pc_q        <= flush_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            type_q[tail_q] <= issue_type_n;
            rd_q[tail_q]   <= issue_rd;
            pc_q[tail_q]   <= issue_pc;
            pred_q[tail_q] <= issue_pred_taken;
        end
        if (cdb_fire) begin
            val_q[cdb_tag]    <= cdb_val;
            taken_q[cdb_tag]  <= cdb_taken;
            target_q[cdb_tag] <= cdb_target;
        end
    end

    assign commit_rf_en    = commit_rf_en_q;
    assign commit_rd       = commit_rd_q;
    assign commit_val      = commit_val_q;
    assign commit_tag      = commit_tag_q;
    assign commit_store_en = commit_store_en_q;
    assign flush           = flush_q;
    assign flush_pc        = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic         issue_valid;
    logic [1:0]   issue_type;
    logic [4:0]   issue_rd;
    logic [31:0]  issue_pc;
    logic         issue_pred_taken;
    logic         rob_full;
    logic [W-1:0] issue_tag;
    logic         cdb_valid;
    logic [W-1:0] cdb_tag;
    logic [31:0]  cdb_val;
    logic         cdb_taken;
    logic [31:0]  cdb_target;
    logic [W-1:0] query1_tag;
    logic [W-1:0] query2_tag;
    logic         query1_ready;
    logic         query2_ready;
    logic [31:0]  query1_val;
    logic [31:0]  query2_val;
    logic         commit_rf_en;
    logic [4:0]   commit_rd;
    logic [31:0]  commit_val;
    logic [W-1:0] commit_tag;
    logic         commit_store_en;
    logic         flush;
    logic [31:0]  flush_pc;

    int vectors     = 0;
    int miscompares = 0;

    reorder_buffer #(.ROB_SIZE(16), .ROB_WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .issue_valid      (issue_valid),
        .issue_type       (issue_type),
        .issue_rd         (issue_rd),
        .issue_pc         (issue_pc),
        .issue_pred_taken (issue_pred_taken),
        .rob_full         (rob_full),
        .issue_tag        (issue_tag),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_val          (cdb_val),
        .cdb_taken        (cdb_taken),
        .cdb_target       (cdb_target),
        .query1_tag       (query1_tag),
        .query2_tag       (query2_tag),
        .query1_ready     (query1_ready),
        .query2_ready     (query2_ready),
        .query1_val       (query1_val),
        .query2_val       (query2_val),
        .commit_rf_en     (commit_rf_en),
        .commit_rd        (commit_rd),
        .commit_val       (commit_val),
        .commit_tag       (commit_tag),
        .commit_store_en  (commit_store_en),
        .flush            (flush),
        .flush_pc         (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pred);
        issue_valid      = 1'b1;
        issue_type       = t;
        issue_rd         = rd;
        issue_pc         = pc;
        issue_pred_taken = pred;
        tick();
        issue_valid      = 1'b0;
    endtask

    task automatic do_cdb(input logic [W-1:0] tag, input logic [31:0] val,
                          input logic taken, input logic [31:0] target);
        cdb_valid  = 1'b1;
        cdb_tag    = tag;
        cdb_val    = val;
        cdb_taken  = taken;
        cdb_target = target;
        tick();
        cdb_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0; issue_pred_taken = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = 32'd0; cdb_taken = 1'b0; cdb_target = 32'd0;
        query1_tag = '0; query2_tag = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_tag", 32'(issue_tag), 32'd0);
        chk("rst_rf_en", 32'(commit_rf_en), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);

        // ALU commit, then rd=0 variant
        do_issue(2'd0, 5'd3, 32'h0, 1'b0);
        chk("alu_issue_tag", 32'(issue_tag), 32'd1);
        do_cdb(4'd0, 32'h1234, 1'b0, 32'h0);
        chk("alu_no_early_commit", 32'(commit_rf_en), 32'd0);
        tick();
        chk("alu_rf_en", 32'(commit_rf_en), 32'd1);
        chk("alu_rd", 32'(commit_rd), 32'd3);
        chk("alu_val", commit_val, 32'h1234);
        chk("alu_tag", 32'(commit_tag), 32'd0);
        tick();
        chk("alu_pulse_end", 32'(commit_rf_en), 32'd0);
        do_issue(2'd0, 5'd0, 32'h4, 1'b0);
        do_cdb(4'd1, 32'h55, 1'b0, 32'h0);
        query1_tag = 4'd1;
        #1;
        chk("rd0_ready_before", 32'(query1_ready), 32'd1);
        tick();
        chk("rd0_rf_en", 32'(commit_rf_en), 32'd0);
        chk("rd0_tag", 32'(commit_tag), 32'd1);
        chk("rd0_retired", 32'(query1_ready), 32'd0);

        // Fill, overflow refusal, commit+issue same cycle, wrap-around
        do_reset();
        issue_valid = 1'b1;
        issue_type  = 2'd0;
        for (int i = 0; i < 16; i++) begin
            issue_rd = 5'(i + 1);
            tick();
        end
        chk("fill_full", 32'(rob_full), 32'd1);
        chk("fill_tag", 32'(issue_tag), 32'd0);
        tick();
        chk("ovf_full", 32'(rob_full), 32'd1);
        chk("ovf_tag", 32'(issue_tag), 32'd0);
        issue_valid = 1'b0;
        do_cdb(4'd0, 32'hA0, 1'b0, 32'h0);
        issue_valid = 1'b1;
        issue_rd    = 5'd20;
        tick();
        chk("wrap_commit", 32'(commit_rf_en), 32'd1);
        chk("wrap_commit_val", commit_val, 32'hA0);
        chk("wrap_refused_tag", 32'(issue_tag), 32'd0);
        chk("wrap_not_full", 32'(rob_full), 32'd0);
        tick();
        issue_valid = 1'b0;
        chk("wrap_accept_tag", 32'(issue_tag), 32'd1);
        chk("wrap_full_again", 32'(rob_full), 32'd1);

        // Out-of-order completion, in-order retirement; type 3 retires as a reg write
        do_reset();
        do_issue(2'd0, 5'd5, 32'h10, 1'b0);
        do_issue(2'd3, 5'd6, 32'h14, 1'b0);
        do_issue(2'd0, 5'd7, 32'h18, 1'b0);
        do_cdb(4'd2, 32'h22, 1'b0, 32'h0);
        chk("ooo_hold1", 32'(commit_rf_en), 32'd0);
        do_cdb(4'd0, 32'h20, 1'b0, 32'h0);
        chk("ooo_hold2", 32'(commit_rf_en), 32'd0);
        do_cdb(4'd1, 32'h21, 1'b0, 32'h0);
        chk("ooo_c0_en", 32'(commit_rf_en), 32'd1);
        chk("ooo_c0_tag", 32'(commit_tag), 32'd0);
        chk("ooo_c0_val", commit_val, 32'h20);
        tick();
        chk("ooo_c1_en", 32'(commit_rf_en), 32'd1);
        chk("ooo_c1_rd", 32'(commit_rd), 32'd6);
        chk("ooo_c1_val", commit_val, 32'h21);
        tick();
        chk("ooo_c2_tag", 32'(commit_tag), 32'd2);
        chk("ooo_c2_rd", 32'(commit_rd), 32'd7);
        tick();
        chk("ooo_done", 32'(commit_rf_en), 32'd0);

        // Branches: taken mispredict with younger entries, correct prediction, not-taken mispredict
        do_reset();
        do_issue(2'd2, 5'd0, 32'h100, 1'b0);
        do_issue(2'd0, 5'd9, 32'h104, 1'b0);
        do_issue(2'd1, 5'd0, 32'h108, 1'b0);
        do_cdb(4'd0, 32'h0, 1'b1, 32'h200);
        do_cdb(4'd1, 32'h99, 1'b0, 32'h0);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_flush_pc", flush_pc, 32'h200);
        chk("br_tail_reset", 32'(issue_tag), 32'd0);
        chk("br_not_full", 32'(rob_full), 32'd0);
        query1_tag  = 4'd1;
        issue_valid = 1'b1;
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd0;
        tick();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        chk("br_younger_cleared", 32'(query1_ready), 32'd0);
        chk("br_issue_ignored", 32'(issue_tag), 32'd0);
        chk("br_pulse_end", 32'(flush), 32'd0);
        do_issue(2'd2, 5'd0, 32'h300, 1'b1);
        do_cdb(4'd0, 32'h0, 1'b1, 32'h400);
        tick();
        chk("br_ok_no_flush", 32'(flush), 32'd0);
        chk("br_ok_tag", 32'(issue_tag), 32'd1);
        do_issue(2'd2, 5'd0, 32'h500, 1'b1);
        do_cdb(4'd1, 32'h0, 1'b0, 32'h999);
        tick();
        chk("br_nt_flush", 32'(flush), 32'd1);
        chk("br_nt_pc", flush_pc, 32'h504);
        tick();
        do_issue(2'd1, 5'd0, 32'h600, 1'b0);
        do_cdb(4'd0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("st_en", 32'(commit_store_en), 32'd1);
        chk("st_tag", 32'(commit_tag), 32'd0);
        chk("st_no_rf", 32'(commit_rf_en), 32'd0);

        // Query bypass, then rdy freeze
        do_reset();
        for (int i = 0; i < 6; i++) do_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
        query1_tag = 4'd5;
        query2_tag = 4'd4;
        cdb_valid  = 1'b1;
        cdb_tag    = 4'd5;
        cdb_val    = 32'hAA;
        #1;
        chk("byp_ready", 32'(query1_ready), 32'd1);
        chk("byp_val", query1_val, 32'hAA);
        chk("q2_not_ready", 32'(query2_ready), 32'd0);
        chk("q2_val_zero", query2_val, 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("stored_val", query1_val, 32'hAA);
        do_cdb(4'd0, 32'h11, 1'b0, 32'h0);
        rdy         = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_no_commit", 32'(commit_rf_en), 32'd0);
            chk("frz_tail", 32'(issue_tag), 32'd6);
        end
        rdy         = 1'b1;
        issue_valid = 1'b0;
        tick();
        chk("frz_resume_en", 32'(commit_rf_en), 32'd1);
        chk("frz_resume_tag", 32'(commit_tag), 32'd0);
        chk("frz_resume_val", commit_val, 32'h11);
        chk("frz_resume_tail", 32'(issue_tag), 32'd6);

        // Asynchronous reset between edges with 5 entries live and a pulse high
        #2;
        rst = 1'b1;
        #1;
        chk("arst_full", 32'(rob_full), 32'd0);
        chk("arst_tag", 32'(issue_tag), 32'd0);
        chk("arst_rf_en", 32'(commit_rf_en), 32'd0);
        chk("arst_store", 32'(commit_store_en), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_val", commit_val, 32'd0);
        chk("arst_q1", 32'(query1_ready), 32'd0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
